// File: rtl/cotm32_pkg.sv
// Shared core definitions used by the load-store unit: datapath widths,
// the load/store operation encoding, LSU FSM states and op-class helpers.
package cotm32_pkg;

  localparam int XLEN         = 32;
  localparam int BYTE_WIDTH   = 8;
  localparam int LSU_BE_WIDTH = XLEN / BYTE_WIDTH;

  // Load/store operation presented by the execute stage; encodings not
  // listed here are treated as "no access".
  typedef enum logic [3:0] {
    LSU_NONE    = 4'd0,
    LSU_LOAD_B  = 4'd1,
    LSU_LOAD_H  = 4'd2,
    LSU_LOAD_W  = 4'd3,
    LSU_LOAD_BU = 4'd4,
    LSU_LOAD_HU = 4'd5,
    LSU_STORE_B = 4'd6,
    LSU_STORE_H = 4'd7,
    LSU_STORE_W = 4'd8
  } lsu_ls_t;

  typedef enum logic [1:0] {
    LSU_S_IDLE = 2'd0,
    LSU_S_REQ  = 2'd1,
    LSU_S_RESP = 2'd2,
    LSU_S_DONE = 2'd3
  } lsu_state_t;

  function automatic logic lsu_is_load(lsu_ls_t op);
    return op inside {LSU_LOAD_B, LSU_LOAD_H, LSU_LOAD_W, LSU_LOAD_BU, LSU_LOAD_HU};
  endfunction

  function automatic logic lsu_is_store(lsu_ls_t op);
    return op inside {LSU_STORE_B, LSU_STORE_H, LSU_STORE_W};
  endfunction

endpackage

// File: rtl/cotm32_lsu_align.sv
// Combinational lane logic for the LSU: byte-enable generation, store data
// replication, low-address force-alignment, misalignment detection and
// load lane select with sign/zero extension.
// Build option: COTM32_LSU_MISALIGN_TRAP_EN enables misalignment detection;
// without it req_misalign is tied low and the offset is force-aligned.
module cotm32_lsu_align
  import cotm32_pkg::*;
(
  input  lsu_ls_t                 req_op,
  input  logic [1:0]              req_off,
  input  logic [XLEN-1:0]         req_wdata,
  output logic [1:0]              req_off_al,
  output logic [LSU_BE_WIDTH-1:0] req_be,
  output logic [XLEN-1:0]         req_lane_data,
  output logic                    req_misalign,
  input  lsu_ls_t                 ld_op,
  input  logic [1:0]              ld_off,
  input  logic [XLEN-1:0]         ld_raw,
  output logic [XLEN-1:0]         ld_data
);

  logic       is_half;
  logic       is_word;
  logic [7:0] ld_byte;
  logic [15:0] ld_half;

  assign is_half = req_op inside {LSU_LOAD_H, LSU_LOAD_HU, LSU_STORE_H};
  assign is_word = req_op inside {LSU_LOAD_W, LSU_STORE_W};

`ifdef COTM32_LSU_MISALIGN_TRAP_EN
  assign req_misalign = (is_half && req_off[0]) || (is_word && (req_off != 2'b00));
`else
  assign req_misalign = 1'b0;
`endif

  // Request side: aligned offset, lane enables and replicated store data.
  always_comb begin
    req_off_al    = req_off;
    req_be        = 4'b0001 << req_off;
    req_lane_data = {4{req_wdata[7:0]}};
    if (is_word) begin
      req_off_al    = 2'b00;
      req_be        = 4'hF;
      req_lane_data = req_wdata;
    end else if (is_half) begin
      req_off_al    = {req_off[1], 1'b0};
      req_be        = 4'b0011 << {req_off[1], 1'b0};
      req_lane_data = {2{req_wdata[15:0]}};
    end
  end

  // Response side: pick the addressed byte/half and extend it.
  always_comb begin
    case (ld_off)
      2'd0:    ld_byte = ld_raw[7:0];
      2'd1:    ld_byte = ld_raw[15:8];
      2'd2:    ld_byte = ld_raw[23:16];
      default: ld_byte = ld_raw[31:24];
    endcase
    ld_half = ld_off[1] ? ld_raw[31:16] : ld_raw[15:0];
    case (ld_op)
      LSU_LOAD_B:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      LSU_LOAD_BU: ld_data = {24'h0, ld_byte};
      LSU_LOAD_H:  ld_data = {{16{ld_half[15]}}, ld_half};
      LSU_LOAD_HU: ld_data = {16'h0, ld_half};
      default:     ld_data = ld_raw;
    endcase
  end

endmodule

// File: rtl/cotm32_lsu.sv
// Load-store unit between execute and data memory. Accepts one access at a
// time, drives a req/gnt/rvalid memory port and returns extended load data
// with a one-cycle lsu_done pulse; stalls the core while an access is open.
// Build option: COTM32_LSU_MISALIGN_TRAP_EN turns misaligned H/W accesses
// into a registered lsu_misalign pulse instead of force-aligning them.
module cotm32_lsu
  import cotm32_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  lsu_ls_t                 ls_op,
  input  logic [XLEN-1:0]         ls_addr,
  input  logic [XLEN-1:0]         ls_wdata,
  output logic                    lsu_stall,
  output logic                    lsu_done,
  output logic [XLEN-1:0]         lsu_rdata,
  output logic                    lsu_misalign,
  output logic                    lsu_misalign_store,
  output logic [XLEN-1:0]         lsu_mtval,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [XLEN-1:0]         mem_addr,
  output logic [LSU_BE_WIDTH-1:0] mem_be,
  output logic [XLEN-1:0]         mem_wdata,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [XLEN-1:0]         mem_rdata,
  output lsu_state_t              lsu_state
);

  // Memory handshake: mem_req is a valid that, once raised, holds addr/be/
  // we/wdata stable until the cycle mem_gnt (ready) is seen high with it;
  // mem_rvalid is only honoured in RESP or alongside the gnt of a load.

  lsu_state_t              state_q, state_d;
  lsu_ls_t                 op_q;
  logic [XLEN-1:0]         addr_q, wdata_q, rdata_q;
  logic [LSU_BE_WIDTH-1:0] be_q;
  logic                    op_valid, can_accept, accept, capture, mis_stall;
  logic [1:0]              off_al;
  logic [LSU_BE_WIDTH-1:0] be_new;
  logic [XLEN-1:0]         wdata_new, ld_data;
  logic                    req_misalign;

  cotm32_lsu_align u_align (
    .req_op        (ls_op),
    .req_off       (ls_addr[1:0]),
    .req_wdata     (ls_wdata),
    .req_off_al    (off_al),
    .req_be        (be_new),
    .req_lane_data (wdata_new),
    .req_misalign  (req_misalign),
    .ld_op         (op_q),
    .ld_off        (addr_q[1:0]),
    .ld_raw        (mem_rdata),
    .ld_data       (ld_data)
  );

  assign op_valid   = lsu_is_load(ls_op) || lsu_is_store(ls_op);
  assign can_accept = (state_q == LSU_S_IDLE) || (state_q == LSU_S_DONE);
  assign accept     = can_accept && op_valid && !req_misalign;

  // State register; reset drops mem_req immediately and abandons any access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LSU_S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and load-data capture strobe.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      LSU_S_IDLE: if (accept) state_d = LSU_S_REQ;
      LSU_S_REQ: begin
        if (mem_gnt) begin
          if (lsu_is_store(op_q)) begin
            state_d = LSU_S_DONE;
          end else if (mem_rvalid) begin
            state_d = LSU_S_DONE;
            capture = 1'b1;
          end else begin
            state_d = LSU_S_RESP;
          end
        end
      end
      LSU_S_RESP: begin
        if (mem_rvalid) begin
          state_d = LSU_S_DONE;
          capture = 1'b1;
        end
      end
      LSU_S_DONE: state_d = accept ? LSU_S_REQ : LSU_S_IDLE;
      default:    state_d = LSU_S_IDLE;
    endcase
  end

  // Latch the accepted access so the request stays stable until granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= LSU_NONE;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      op_q    <= ls_op;
      addr_q  <= {ls_addr[XLEN-1:2], off_al};
      be_q    <= be_new;
      wdata_q <= wdata_new;
    end
  end

  // Register the extended load result; it is presented with lsu_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rdata_q <= '0;
    else if (capture) rdata_q <= ld_data;
  end

`ifdef COTM32_LSU_MISALIGN_TRAP_EN
  logic            mis_now, mis_q, mis_store_q;
  logic [XLEN-1:0] mtval_q;

  // A held misaligned op reports once, then waits for the core to trap.
  assign mis_now   = can_accept && op_valid && req_misalign && !mis_q;
  assign mis_stall = mis_now && (state_q == LSU_S_IDLE);

  // One-cycle misalignment report, registered from the presentation cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_q       <= 1'b0;
      mis_store_q <= 1'b0;
      mtval_q     <= '0;
    end else begin
      mis_q <= mis_now;
      if (mis_now) begin
        mis_store_q <= lsu_is_store(ls_op);
        mtval_q     <= ls_addr;
      end
    end
  end

  assign lsu_misalign       = mis_q;
  assign lsu_misalign_store = mis_q && mis_store_q;
  assign lsu_mtval          = mis_q ? mtval_q : '0;
`else
  assign mis_stall          = 1'b0;
  assign lsu_misalign       = 1'b0;
  assign lsu_misalign_store = 1'b0;
  assign lsu_mtval          = '0;
`endif

  assign lsu_stall = (state_q inside {LSU_S_REQ, LSU_S_RESP}) ||
                     ((state_q == LSU_S_IDLE) && accept) || mis_stall;
  assign lsu_done  = (state_q == LSU_S_DONE);
  assign lsu_rdata = rdata_q;
  assign lsu_state = state_q;

  assign mem_req   = (state_q == LSU_S_REQ);
  assign mem_we    = lsu_is_store(op_q);
  assign mem_addr  = {addr_q[XLEN-1:2], 2'b00};
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_cotm32_lsu.sv
// Directed bench for cotm32_lsu: a memory responder with programmable
// gnt/rvalid delays, an expected-load-data queue and a final summary.
// Build option COTM32_LSU_MISALIGN_TRAP_EN selects the trap-mode checks.
module tb_cotm32_lsu;
  import cotm32_pkg::*;

  logic            clk;
  logic            rst_n;
  lsu_ls_t         ls_op;
  logic [31:0]     ls_addr, ls_wdata;
  logic            lsu_stall, lsu_done, lsu_misalign, lsu_misalign_store;
  logic [31:0]     lsu_rdata, lsu_mtval;
  logic            mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0]     mem_addr, mem_wdata, mem_rdata;
  logic [3:0]      mem_be;
  lsu_state_t      lsu_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  cotm32_lsu dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .ls_op              (ls_op),
    .ls_addr            (ls_addr),
    .ls_wdata           (ls_wdata),
    .lsu_stall          (lsu_stall),
    .lsu_done           (lsu_done),
    .lsu_rdata          (lsu_rdata),
    .lsu_misalign       (lsu_misalign),
    .lsu_misalign_store (lsu_misalign_store),
    .lsu_mtval          (lsu_mtval),
    .mem_req            (mem_req),
    .mem_we             (mem_we),
    .mem_addr           (mem_addr),
    .mem_be             (mem_be),
    .mem_wdata          (mem_wdata),
    .mem_gnt            (mem_gnt),
    .mem_rvalid         (mem_rvalid),
    .mem_rdata          (mem_rdata),
    .lsu_state          (lsu_state)
  );

  // Clock and global watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive a new op at the falling edge; combinational outputs settle by #1.
  task automatic present(input lsu_ls_t op, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    ls_op    = op;
    ls_addr  = a;
    ls_wdata = wd;
    mem_gnt  = 1'b0;
    mem_rvalid = 1'b0;
    #1;
  endtask

  // Play memory for one access already accepted; checks request stability,
  // stall, latency, and (for loads) pops the expected data at lsu_done.
  // In the done cycle the next op (possibly LSU_NONE) is presented.
  task automatic serve(input logic is_ld, input logic [31:0] word,
                       input int gnt_dly, input int rv_dly,
                       input logic [31:0] e_addr, input logic [3:0] e_be,
                       input logic [31:0] e_wd, input int e_lat,
                       input lsu_ls_t nxt_op, input logic [31:0] nxt_addr,
                       input logic [31:0] nxt_wd);
    int cyc, req_cyc, gnt_cyc;
    bit granted, done_seen;
    logic [31:0] exp_d;
    cyc = 0; req_cyc = 0; gnt_cyc = 0; granted = 0; done_seen = 0;
    while (!done_seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      if (lsu_done) begin
        done_seen = 1;
        ls_op = nxt_op; ls_addr = nxt_addr; ls_wdata = nxt_wd;
        #1;
        check("latency", cyc, e_lat);
        check1("done_stall", lsu_stall, 1'b0);
        if (is_ld) begin
          if (exp_q.size() == 0) begin
            check("sb_underflow", 32'd0, 32'd1);
          end else begin
            exp_d = exp_q.pop_front();
            check("load_data", lsu_rdata, exp_d);
          end
        end
      end else begin
        ls_op = LSU_NONE;
        if (mem_req) begin
          check("req_addr", mem_addr, e_addr);
          check("req_be", {28'h0, mem_be}, {28'h0, e_be});
          check1("req_we", mem_we, !is_ld);
          if (!is_ld) check("req_wdata", mem_wdata, e_wd);
          if (req_cyc == gnt_dly) begin
            mem_gnt = 1'b1; granted = 1; gnt_cyc = cyc;
            if (is_ld && rv_dly == 0) begin mem_rvalid = 1'b1; mem_rdata = word; end
          end
          req_cyc++;
        end else if (granted && is_ld && (cyc - gnt_cyc == rv_dly)) begin
          mem_rvalid = 1'b1; mem_rdata = word;
        end
        #1;
        check1("busy_stall", lsu_stall, 1'b1);
      end
    end
    if (!done_seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; ls_op = LSU_NONE; ls_addr = '0; ls_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    check1("rst_mem_req", mem_req, 1'b0);
    check1("rst_done", lsu_done, 1'b0);
    check("rst_rdata", lsu_rdata, 32'h0);
    check1("rst_misalign", lsu_misalign, 1'b0);
    check1("rst_stall", lsu_stall, 1'b0);
    check("rst_state", {30'h0, lsu_state}, {30'h0, LSU_S_IDLE});
    @(negedge clk);
    rst_n = 1'b1;

    // STORE_B to byte 3: lane 3 enabled, data replicated.
    present(LSU_STORE_B, 32'h103, 32'h0000_00A5);
    check1("t1_accept_stall", lsu_stall, 1'b1);
    serve(1'b0, 32'h0, 0, 0, 32'h100, 4'b1000, 32'hA5A5_A5A5, 2, LSU_NONE, 32'h0, 32'h0);

    // Signed and unsigned byte loads from lane 2.
    present(LSU_LOAD_B, 32'h102, 32'h0);
    check1("t2_accept_stall", lsu_stall, 1'b1);
    exp_q.push_back(32'hFFFF_FFF0);
    serve(1'b1, 32'h12F0_3456, 0, 1, 32'h100, 4'b0100, 32'h0, 3, LSU_NONE, 32'h0, 32'h0);
    present(LSU_LOAD_BU, 32'h102, 32'h0);
    exp_q.push_back(32'h0000_00F0);
    serve(1'b1, 32'h12F0_3456, 0, 1, 32'h100, 4'b0100, 32'h0, 3, LSU_NONE, 32'h0, 32'h0);

    // Slow memory: gnt after 3 wait cycles, rvalid 2 cycles after gnt.
    present(LSU_LOAD_H, 32'h200, 32'h0);
    exp_q.push_back(32'hFFFF_8001);
    serve(1'b1, 32'hABCD_8001, 3, 2, 32'h200, 4'b0011, 32'h0, 7, LSU_NONE, 32'h0, 32'h0);

    // Upper half, zero-extended.
    present(LSU_LOAD_HU, 32'h202, 32'h0);
    exp_q.push_back(32'h0000_8001);
    serve(1'b1, 32'h8001_ABCD, 0, 1, 32'h200, 4'b1100, 32'h0, 3, LSU_NONE, 32'h0, 32'h0);

    // rvalid together with gnt: load finishes in store time.
    present(LSU_LOAD_W, 32'h500, 32'h0);
    exp_q.push_back(32'h1357_9BDF);
    serve(1'b1, 32'h1357_9BDF, 0, 0, 32'h500, 4'hF, 32'h0, 2, LSU_NONE, 32'h0, 32'h0);

    // Back-to-back: LOAD_W accepted in the DONE cycle of STORE_W.
    present(LSU_STORE_W, 32'h300, 32'hDEAD_BEEF);
    exp_q.push_back(32'hCAFE_F00D);
    serve(1'b0, 32'h0, 0, 0, 32'h300, 4'hF, 32'hDEAD_BEEF, 2, LSU_LOAD_W, 32'h304, 32'h0);
    serve(1'b1, 32'hCAFE_F00D, 0, 1, 32'h304, 4'hF, 32'h0, 3, LSU_NONE, 32'h0, 32'h0);

`ifdef COTM32_LSU_MISALIGN_TRAP_EN
    // Misaligned word store traps instead of reaching memory.
    present(LSU_STORE_W, 32'h101, 32'h1122_3344);
    check1("t5_pres_stall", lsu_stall, 1'b1);
    @(negedge clk);
    ls_op = LSU_NONE;
    #1;
    check1("t5_misalign", lsu_misalign, 1'b1);
    check1("t5_mis_store", lsu_misalign_store, 1'b1);
    check("t5_mtval", lsu_mtval, 32'h101);
    check1("t5_no_req", mem_req, 1'b0);
    check1("t5_no_stall", lsu_stall, 1'b0);
    @(negedge clk);
    #1;
    check1("t5_pulse_end", lsu_misalign, 1'b0);
    check1("t5_still_no_req", mem_req, 1'b0);
`else
    // Misaligned accesses are force-aligned and proceed.
    present(LSU_STORE_W, 32'h101, 32'h1122_3344);
    check1("t5_accept_stall", lsu_stall, 1'b1);
    serve(1'b0, 32'h0, 0, 0, 32'h100, 4'hF, 32'h1122_3344, 2, LSU_NONE, 32'h0, 32'h0);
    check1("t5_misalign_tied", lsu_misalign, 1'b0);
    check("t5_mtval_tied", lsu_mtval, 32'h0);
    present(LSU_STORE_H, 32'h103, 32'h0000_BEEF);
    serve(1'b0, 32'h0, 0, 0, 32'h100, 4'b1100, 32'hBEEF_BEEF, 2, LSU_NONE, 32'h0, 32'h0);
`endif

    // Reserved encoding behaves as no access.
    present(lsu_ls_t'(4'hC), 32'h600, 32'h0);
    check1("rsv_stall", lsu_stall, 1'b0);
    @(negedge clk);
    ls_op = LSU_NONE;
    #1;
    check1("rsv_no_req", mem_req, 1'b0);
    check("rsv_state", {30'h0, lsu_state}, {30'h0, LSU_S_IDLE});

    // Reset while waiting for rvalid; the late response must be ignored.
    present(LSU_LOAD_W, 32'h400, 32'h0);
    @(negedge clk);
    ls_op = LSU_NONE; mem_gnt = 1'b1;
    #1;
    check1("t6_req", mem_req, 1'b1);
    @(negedge clk);
    mem_gnt = 1'b0;
    #1;
    check("t6_in_resp", {30'h0, lsu_state}, {30'h0, LSU_S_RESP});
    rst_n = 1'b0;
    #1;
    check1("t6_rst_req", mem_req, 1'b0);
    check1("t6_rst_done", lsu_done, 1'b0);
    check("t6_rst_state", {30'h0, lsu_state}, {30'h0, LSU_S_IDLE});
    @(negedge clk);
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_DEAD;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    #1;
    check1("t6_stray_done", lsu_done, 1'b0);
    check("t6_stray_rdata", lsu_rdata, 32'h0);
    check("t6_stray_state", {30'h0, lsu_state}, {30'h0, LSU_S_IDLE});
    present(LSU_LOAD_W, 32'h404, 32'h0);
    exp_q.push_back(32'h0F0F_1234);
    serve(1'b1, 32'h0F0F_1234, 0, 1, 32'h404, 4'hF, 32'h0, 3, LSU_NONE, 32'h0, 32'h0);

    check("sb_leftover", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
